// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: Tuse/Tnew encodings, MDU FSM states, handler entry PC.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

  // Tuse: cycles until D needs the operand; TUSE_NONE means the operand is not read.
  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Tnew: cycles until a producer's result can be forwarded.
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam int MD_CNT_W = 4;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [31:0] EXC_PC_DEFAULT = 32'h0000_4180;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the datapath (master) and the hazard controller (slave).
// Latency: n/a (wires only).
// Backpressure: stall_fd/flush_e hold and bubble the front end; req overrides both.
// Ports: D-stage operand info, E/M producer info, MDU start, exception request in;
//        stall_fd, flush_e, req, exc_pc, md_busy out of the controller.
interface pipe_hazard_ctrl_if;
  import pipe_pkg::*;

  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic [1:0]  d_tuse_rs;
  logic [1:0]  d_tuse_rt;
  logic        d_is_md;
  logic [4:0]  e_wa;
  logic [1:0]  e_tnew;
  logic [4:0]  m_wa;
  logic [1:0]  m_tnew;
  logic        e_md_start;
  logic        e_md_div;
  logic        m_exc_req;
  logic        stall_fd;
  logic        flush_e;
  logic        req;
  logic [31:0] exc_pc;
  logic        md_busy;

  // Datapath side.
  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md,
    output e_wa, e_tnew, m_wa, m_tnew,
    output e_md_start, e_md_div, m_exc_req,
    input  stall_fd, flush_e, req, exc_pc, md_busy
  );

  // Controller side.
  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md,
    input  e_wa, e_tnew, m_wa, m_tnew,
    input  e_md_start, e_md_div, m_exc_req,
    output stall_fd, flush_e, req, exc_pc, md_busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_tracker.sv
// Tracks the multi-cycle mult/div unit: loads a cycle count on start, counts down to idle.
// Latency: busy rises one cycle after start and stays high for exactly the loaded count.
// Backpressure: a start that is cancelled, or arrives while busy, is dropped (no reload).
// Ports: clk, reset (sync, active-high), start, is_div, cancel in; busy out.
module md_busy_tracker
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  input  logic cancel,
  output logic busy
);

  if (DIV_CYCLES > 15 || DIV_CYCLES < 1 || MULT_CYCLES > 15 || MULT_CYCLES < 1) begin : g_bad_cycles
    $error("md_busy_tracker: cycle counts must be in 1..15 to fit the 4-bit counter");
  end

  md_state_t             state, state_nxt;
  logic [MD_CNT_W-1:0]   cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      MD_IDLE: begin
        // A start flushed by an exception in the same cycle never reaches the unit.
        if (start && !cancel) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = is_div ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
        end
      end
      MD_BUSY: begin
        // Keeps counting through exceptions: the operation already issued completes.
        cnt_nxt = cnt - 1'b1;
        if (cnt == MD_CNT_W'(1)) state_nxt = MD_IDLE;
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the pipeline registers: Tuse/Tnew hazards, MDU wait, exception flush.
// Latency: stall_fd/flush_e/req combinational same-cycle; md_busy one cycle after e_md_start.
// Backpressure: stall holds PC and F/D and bubbles D/E; req overrides stall and flushes everything.
// Ports: clk, reset (sync, active-high), hz (slave side of pipe_hazard_ctrl_if).
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int          MULT_CYCLES = 5,
  parameter int          DIV_CYCLES  = 10,
  parameter logic [31:0] EXC_PC      = EXC_PC_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  pipe_hazard_ctrl_if.slave hz
);

  logic hz_rs, hz_rt, hz_md, stall, md_busy;

  // A producer hazards an operand only if its result arrives later than the operand is needed.
  // $0 never hazards: it is hard-wired and any "write" to it is discarded.
  assign hz_rs = (hz.d_rs != 5'd0) &&
                 (((hz.d_rs == hz.e_wa) && (hz.e_tnew > hz.d_tuse_rs)) ||
                  ((hz.d_rs == hz.m_wa) && (hz.m_tnew > hz.d_tuse_rs)));

  assign hz_rt = (hz.d_rt != 5'd0) &&
                 (((hz.d_rt == hz.e_wa) && (hz.e_tnew > hz.d_tuse_rt)) ||
                  ((hz.d_rt == hz.m_wa) && (hz.m_tnew > hz.d_tuse_rt)));

  // e_md_start covers the cycle before the counter has loaded.
  assign hz_md = hz.d_is_md && (md_busy || hz.e_md_start);

  assign stall = hz_rs | hz_rt | hz_md;

  // The exception flush clears every stage, so holding anything would only re-fetch stale state.
  assign hz.req      = hz.m_exc_req;
  assign hz.stall_fd = stall & ~hz.req;
  assign hz.flush_e  = stall & ~hz.req;
  assign hz.exc_pc   = EXC_PC;
  assign hz.md_busy  = md_busy;

  md_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md (
    .clk    (clk),
    .reset  (reset),
    .start  (hz.e_md_start),
    .is_div (hz.e_md_div),
    .cancel (hz.req),
    .busy   (md_busy)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle expectations queued, then compared at negedge.
// Latency: inputs driven 1 time unit after posedge, outputs sampled at the following negedge.
// Backpressure: n/a.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  // Expected {stall_fd, flush_e, req, md_busy} per driven cycle.
  logic [3:0] sb[$];
  logic [3:0] exp_v;
  logic [3:0] got_v;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A start must never be issued while the unit is busy; the hazard logic holds it in D.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(hz.e_md_start && hz.md_busy))
        else $error("FAIL start_while_busy: e_md_start seen with md_busy=1");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_idle();
    hz.d_rs       = 5'd0;
    hz.d_rt       = 5'd0;
    hz.d_tuse_rs  = TUSE_NONE;
    hz.d_tuse_rt  = TUSE_NONE;
    hz.d_is_md    = 1'b0;
    hz.e_wa       = 5'd0;
    hz.e_tnew     = TNEW_0;
    hz.m_wa       = 5'd0;
    hz.m_tnew     = TNEW_0;
    hz.e_md_start = 1'b0;
    hz.e_md_div   = 1'b0;
    hz.m_exc_req  = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    repeat (3) next_cycle();
    sb.push_back(4'b0000);
    @(negedge clk);
    exp_v = sb.pop_front();
    got_v = {hz.stall_fd, hz.flush_e, hz.req, hz.md_busy};
    n_chk++;
    if (got_v !== exp_v) $display("FAIL reset_outputs: got %b want %b", got_v, exp_v);
    else n_pass++;
    n_chk++;
    if (hz.exc_pc !== 32'h0000_4180) $display("FAIL reset_exc_pc: got %h want %h", hz.exc_pc, 32'h4180);
    else n_pass++;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_data_hazard();
    // Load-use on rs from E: result in 2 cycles, needed in 1.
    set_idle();
    hz.e_wa = 5'd8; hz.e_tnew = 2'd2; hz.d_rs = 5'd8; hz.d_tuse_rs = 2'd1;
    sb.push_back(4'b1100);
    @(negedge clk);
    exp_v = sb.pop_front();
    got_v = {hz.stall_fd, hz.flush_e, hz.req, hz.md_busy};
    n_chk++;
    if (got_v !== exp_v) $display("FAIL load_use_rs: got %b want %b", got_v, exp_v);
    else n_pass++;

    // Producer ready in time: forwarding suffices.
    next_cycle();
    hz.e_tnew = 2'd1;
    sb.push_back(4'b0000);
    @(negedge clk);
    exp_v = sb.pop_front();
    got_v = {hz.stall_fd, hz.flush_e, hz.req, hz.md_busy};
    n_chk++;
    if (got_v !== exp_v) $display("FAIL load_use_tnew1: got %b want %b", got_v, exp_v);
    else n_pass++;

    // rt against the M-stage producer, needed immediately.
    next_cycle();
    set_idle();
    hz.m_wa = 5'd9; hz.m_tnew = 2'd1; hz.d_rt = 5'd9; hz.d_tuse_rt = 2'd0;
    sb.push_back(4'b1100);
    @(negedge clk);
    exp_v = sb.pop_front();
    got_v = {hz.stall_fd, hz.flush_e, hz.req, hz.md_busy};
    n_chk++;
    if (got_v !== exp_v) $display("FAIL m_hazard_rt: got %b want %b", got_v, exp_v);
    else n_pass++;

    // Same registers but rt unused.
    next_cycle();
    hz.d_tuse_rt = TUSE_NONE;
    sb.push_back(4'b0000);
    @(negedge clk);
    exp_v = sb.pop_front();
    got_v = {hz.stall_fd, hz.flush_e, hz.req, hz.md_busy};
    n_chk++;
    if (got_v !== exp_v) $display("FAIL rt_unused: got %b want %b", got_v, exp_v);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_zero_reg();
    set_idle();
    hz.d_rs = 5'd0; hz.e_wa = 5'd0; hz.e_tnew = 2'd2; hz.d_tuse_rs = 2'd0;
    sb.push_back(4'b0000);
    @(negedge clk);
    exp_v = sb.pop_front();
    got_v = {hz.stall_fd, hz.flush_e, hz.req, hz.md_busy};
    n_chk++;
    if (got_v !== exp_v) $display("FAIL zero_reg_exempt: got %b want %b", got_v, exp_v);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_mult();
    set_idle();
    hz.d_is_md = 1'b1;
    for (int k = 0; k < 8; k++) begin
      hz.e_md_start = (k == 0);
      hz.e_md_div   = 1'b0;
      // Busy cycles 1..5; D stalls from the start cycle through the last busy cycle.
      sb.push_back({(k <= 5), (k <= 5), 1'b0, (k >= 1 && k <= 5)});
      @(negedge clk);
      exp_v = sb.pop_front();
      got_v = {hz.stall_fd, hz.flush_e, hz.req, hz.md_busy};
      n_chk++;
      if (got_v !== exp_v) $display("FAIL mult k=%0d: got %b want %b", k, got_v, exp_v);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_div();
    set_idle();
    for (int k = 0; k < 12; k++) begin
      hz.e_md_start = (k == 0);
      hz.e_md_div   = (k == 0);
      sb.push_back({2'b00, 1'b0, (k >= 1 && k <= 10)});
      @(negedge clk);
      exp_v = sb.pop_front();
      got_v = {hz.stall_fd, hz.flush_e, hz.req, hz.md_busy};
      n_chk++;
      if (got_v !== exp_v) $display("FAIL div k=%0d: got %b want %b", k, got_v, exp_v);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_exc_cancel();
    set_idle();
    hz.d_is_md = 1'b1;
    for (int k = 0; k < 4; k++) begin
      hz.e_md_start = (k == 0);
      hz.m_exc_req  = (k == 0);
      hz.d_is_md    = (k == 0);
      sb.push_back({2'b00, (k == 0), 1'b0});
      @(negedge clk);
      exp_v = sb.pop_front();
      got_v = {hz.stall_fd, hz.flush_e, hz.req, hz.md_busy};
      n_chk++;
      if (got_v !== exp_v) $display("FAIL exc_cancel k=%0d: got %b want %b", k, got_v, exp_v);
      else n_pass++;
      if (k == 0) begin
        n_chk++;
        if (hz.exc_pc !== 32'h0000_4180) $display("FAIL exc_pc: got %h want %h", hz.exc_pc, 32'h4180);
        else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_exc_while_busy();
    set_idle();
    for (int k = 0; k < 7; k++) begin
      hz.e_md_start = (k == 0);
      hz.e_md_div   = 1'b0;
      hz.m_exc_req  = (k == 2);
      hz.d_is_md    = (k == 2);
      // The exception masks the MDU stall; the counter runs its full 5 cycles.
      sb.push_back({2'b00, (k == 2), (k >= 1 && k <= 5)});
      @(negedge clk);
      exp_v = sb.pop_front();
      got_v = {hz.stall_fd, hz.flush_e, hz.req, hz.md_busy};
      n_chk++;
      if (got_v !== exp_v) $display("FAIL exc_busy k=%0d: got %b want %b", k, got_v, exp_v);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_div();
    set_idle();
    for (int k = 0; k < 8; k++) begin
      hz.e_md_start = (k == 0);
      hz.e_md_div   = (k == 0);
      // Counter reads 11-k during cycle k, so reset is applied while it holds 6.
      reset         = (k == 5);
      hz.d_is_md    = (k >= 6);
      sb.push_back({2'b00, 1'b0, (k >= 1 && k <= 5)});
      @(negedge clk);
      exp_v = sb.pop_front();
      got_v = {hz.stall_fd, hz.flush_e, hz.req, hz.md_busy};
      n_chk++;
      if (got_v !== exp_v) $display("FAIL reset_mid_div k=%0d: got %b want %b", k, got_v, exp_v);
      else n_pass++;
      if (k == 6) begin
        n_chk++;
        if (dut.u_md.state !== MD_IDLE)
          $display("FAIL reset_mid_div_state: got %0d want %0d", dut.u_md.state, MD_IDLE);
        else n_pass++;
      end
      next_cycle();
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Mult immediately followed by div once idle.
    set_idle();
    for (int k = 0; k < 18; k++) begin
      hz.e_md_start = (k == 0) || (k == 6);
      hz.e_md_div   = (k == 6);
      sb.push_back({2'b00, 1'b0, (k >= 1 && k <= 5) || (k >= 7 && k <= 16)});
      @(negedge clk);
      exp_v = sb.pop_front();
      got_v = {hz.stall_fd, hz.flush_e, hz.req, hz.md_busy};
      n_chk++;
      if (got_v !== exp_v) $display("FAIL back_to_back k=%0d: got %b want %b", k, got_v, exp_v);
      else n_pass++;
      next_cycle();
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_data_hazard();
    test_zero_reg();
    test_mult();
    test_div();
    test_exc_cancel();
    test_exc_while_busy();
    test_reset_mid_div();
    test_back_to_back();
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
